uart_tx: RTL



---
 rtl/uart_tx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmit serialiser.
// Sends start bit, LSB-first data, optional parity, then stop bit,
// one line bit per CLK cycle. A new word may be accepted in IDLE, or
// during the stop bit so that frames run back-to-back with no idle gap.
// Optional feature macro: UART_TX_PARITY_EN (parity bit support).
// Without it, Parity_EN and Parity_type are accepted but ignored.
module uart_tx #(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [width-1:0] P_Data,
    input  logic             Data_valid,
    input  logic             Parity_EN,
    input  logic             Parity_type,
    output logic             TX_OUT,
    output logic             Busy
);

    localparam int CNT_W = $clog2(width);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [width-1:0]   data_q;
    logic               tx_q;
    logic               busy_q;
    logic               accept_d;

    // A word is taken only when the line is idle or finishing a stop bit.
    assign accept_d = Data_valid && ((state_q == IDLE) || (state_q == STOP));

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic parity_q;
    logic parity_d;

    // Even parity over the data, inverted when odd parity is requested.
    assign parity_d = (^P_Data) ^ Parity_type;
`else
    logic unused_parity_inputs;

    // Parity controls have no effect in this build.
    assign unused_parity_inputs = Parity_EN ^ Parity_type;
`endif

    // Frame sequencer; the line bit is registered together with the state
    // so that TX_OUT always reflects the bit of the current state.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
`endif
        end else begin
            // Frame contents are frozen at the accepting edge.
            if (accept_d) begin
                data_q   <= P_Data;
`ifdef UART_TX_PARITY_EN
                par_en_q <= Parity_EN;
                parity_q <= parity_d;
`endif
            end

            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        state_q <= START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    state_q <= DATA;
                    cnt_q   <= '0;
                    tx_q    <= data_q[0];
                end
                DATA: begin
                    if (cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_q <= PARITY;
                            tx_q    <= parity_q;
                        end else begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end
`else
                        state_q <= STOP;
                        tx_q    <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        tx_q  <= data_q[cnt_q + 1'b1];
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    state_q <= STOP;
                    tx_q    <= 1'b1;
                end
`endif
                STOP: begin
                    // Back-to-back accept goes straight to the next start bit.
                    state_q <= accept_d ? START : IDLE;
                    tx_q    <= ~accept_d;
                    busy_q  <= accept_d;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

endmodule
